// File: rtl/io_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : io_bus_arbiter_if
// Description : Signal bundle between the two bus masters, the arbiter and
//               the CPU-side port of the IO/memory hub.
// Revision    : 1.0 - initial release
// ============================================================================
interface io_bus_arbiter_if;
    // Master 0 (CPU) request side
    logic        m0_req;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_we;
    logic        m0_lock;
    logic        m0_gnt;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;
    // Master 1 (DMA / debug loader) request side
    logic        m1_req;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_we;
    logic        m1_lock;
    logic        m1_gnt;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;
    // Hub port
    logic [31:0] bus_addr;
    logic [31:0] bus_datain;
    logic        bus_we;
    logic [31:0] bus_dataout;

    // Arbiter view
    modport slave (
        input  m0_req, m0_addr, m0_wdata, m0_we, m0_lock,
        input  m1_req, m1_addr, m1_wdata, m1_we, m1_lock,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output bus_addr, bus_datain, bus_we,
        input  bus_dataout
    );

    // Environment view: both requesters plus the hub behind the bus port
    modport master (
        output m0_req, m0_addr, m0_wdata, m0_we, m0_lock,
        output m1_req, m1_addr, m1_wdata, m1_we, m1_lock,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  bus_addr, bus_datain, bus_we,
        output bus_dataout
    );
endinterface
`default_nettype wire

// File: rtl/io_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : io_bus_arbiter
// Description : Two-master arbiter in front of the IO/memory hub. Every
//               access runs IDLE -> ISSUE -> RESP; supports round-robin or
//               fixed priority and a bounded bus lock for read-modify-write.
// Revision    : 1.0 - initial release
// ============================================================================
module io_bus_arbiter #(
    parameter int FIXED_PRIO = 0,
    parameter int LOCK_MAX   = 4
) (
    input  logic              clock,
    input  logic              reset,
    io_bus_arbiter_if.slave   io
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_RESP  = 2'd2;
    localparam logic [3:0] c_LOCK_MAX = 4'(LOCK_MAX);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_last_grant;   // doubles as the lock owner
    logic        r_lock_active;
    logic [3:0]  r_lock_cnt;
    logic        r_winner;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic        r_m0_rvalid;
    logic        r_m1_rvalid;
    logic [31:0] r_m0_rdata;
    logic [31:0] r_m1_rdata;

    logic w_owner_req;
    logic w_other_req;
    logic w_lock_break;
    logic w_lock_hold;
    logic w_elig0;
    logic w_elig1;
    logic w_any;
    logic w_pick;
    logic w_win_lock;

    // Lock bookkeeping seen from the owner's point of view
    assign w_owner_req  = r_last_grant ? io.m1_req : io.m0_req;
    assign w_other_req  = r_last_grant ? io.m0_req : io.m1_req;
    // A lock that has been held long enough is broken before arbitration
    assign w_lock_break = r_lock_active && (r_lock_cnt >= c_LOCK_MAX);
    // The lock survives this arbitration only if the owner still asks for it
    assign w_lock_hold  = r_lock_active && w_owner_req && !w_lock_break;

    // On a break the former owner steps aside so the waiting master wins
    assign w_elig0 = io.m0_req
                     && !(w_lock_hold && r_last_grant)
                     && !(w_lock_break && !r_last_grant && io.m1_req);
    assign w_elig1 = io.m1_req
                     && !(w_lock_hold && !r_last_grant)
                     && !(w_lock_break && r_last_grant && io.m0_req);
    assign w_any   = w_elig0 || w_elig1;
    assign w_pick  = (w_elig0 && w_elig1)
                     ? ((FIXED_PRIO != 0) ? 1'b0 : ~r_last_grant)
                     : w_elig1;
    assign w_win_lock = w_pick ? io.m1_lock : io.m0_lock;

    // State register
    always_ff @(posedge clock) begin
        if (reset) r_state <= c_ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state and the phase-dependent outputs
    always_comb begin
        w_state_nxt = r_state;
        io.m0_gnt   = 1'b0;
        io.m1_gnt   = 1'b0;
        io.bus_we   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_any) w_state_nxt = c_ST_ISSUE;
            end
            c_ST_ISSUE: begin
                io.m0_gnt   = !r_winner;
                io.m1_gnt   = r_winner;
                io.bus_we   = r_we;
                w_state_nxt = c_ST_RESP;
            end
            c_ST_RESP: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Request capture, arbitration history, lock tracking and read return
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_grant  <= 1'b1;
            r_lock_active <= 1'b0;
            r_lock_cnt    <= 4'd0;
            r_winner      <= 1'b0;
            r_addr        <= 32'd0;
            r_wdata       <= 32'd0;
            r_we          <= 1'b0;
            r_m0_rvalid   <= 1'b0;
            r_m1_rvalid   <= 1'b0;
            r_m0_rdata    <= 32'd0;
            r_m1_rdata    <= 32'd0;
        end else begin
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any) begin
                        r_winner     <= w_pick;
                        r_last_grant <= w_pick;
                        r_addr       <= w_pick ? io.m1_addr  : io.m0_addr;
                        r_wdata      <= w_pick ? io.m1_wdata : io.m0_wdata;
                        r_we         <= w_pick ? io.m1_we    : io.m0_we;
                        if (w_win_lock) begin
                            r_lock_active <= 1'b1;
                            // Only contended re-grants count toward the break
                            if (w_lock_hold)
                                r_lock_cnt <= r_lock_cnt + 4'(w_other_req);
                            else
                                r_lock_cnt <= 4'd0;
                        end else begin
                            r_lock_active <= 1'b0;
                            r_lock_cnt    <= 4'd0;
                        end
                    end else begin
                        r_lock_active <= w_lock_hold;
                        if (!w_lock_hold) r_lock_cnt <= 4'd0;
                    end
                end
                c_ST_RESP: begin
                    if (r_winner) begin
                        r_m1_rvalid <= 1'b1;
                        r_m1_rdata  <= r_we ? 32'd0 : io.bus_dataout;
                    end else begin
                        r_m0_rvalid <= 1'b1;
                        r_m0_rdata  <= r_we ? 32'd0 : io.bus_dataout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign io.bus_addr   = r_addr;
    assign io.bus_datain = r_wdata;
    assign io.m0_rvalid  = r_m0_rvalid;
    assign io.m1_rvalid  = r_m1_rvalid;
    assign io.m0_rdata   = r_m0_rdata;
    assign io.m1_rdata   = r_m1_rdata;

endmodule
`default_nettype wire

// File: tb/tb_io_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_bus_arbiter
// Description : Directed, table-driven bench for io_bus_arbiter. A round-robin
//               instance is the main target; a fixed-priority instance
//               shares its inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_bus_arbiter;

    typedef struct {
        logic        r0;
        logic [31:0] a0;
        logic        r1;
        logic [31:0] a1;
        logic [31:0] d1;
        logic        w1;
        logic [31:0] dout;
        logic        g0, g1, v0, v1, bwe;
        logic [31:0] baddr, bdin, rd0, rd1;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    vec_t       tbl[22];
    int         m1_cnt;
    bit         m0_seen;
    int         n0, n1, last_c;
    logic [3:0] p0, p1;
    bit         gap_ok;

    io_bus_arbiter_if if0();
    io_bus_arbiter_if if1();

    io_bus_arbiter #(.FIXED_PRIO(0), .LOCK_MAX(4)) dut0 (
        .clock (clk),
        .reset (rst),
        .io    (if0)
    );

    io_bus_arbiter #(.FIXED_PRIO(1), .LOCK_MAX(4)) dut1 (
        .clock (clk),
        .reset (rst),
        .io    (if1)
    );

    // The fixed-priority instance sees the same masters and hub
    assign if1.m0_req      = if0.m0_req;
    assign if1.m0_addr     = if0.m0_addr;
    assign if1.m0_wdata    = if0.m0_wdata;
    assign if1.m0_we       = if0.m0_we;
    assign if1.m0_lock     = if0.m0_lock;
    assign if1.m1_req      = if0.m1_req;
    assign if1.m1_addr     = if0.m1_addr;
    assign if1.m1_wdata    = if0.m1_wdata;
    assign if1.m1_we       = if0.m1_we;
    assign if1.m1_lock     = if0.m1_lock;
    assign if1.bus_dataout = if0.bus_dataout;

    always #5 clk = ~clk;

    function automatic vec_t V(input logic r0, input logic [31:0] a0,
                               input logic r1, input logic [31:0] a1,
                               input logic [31:0] d1, input logic w1,
                               input logic [31:0] dout,
                               input logic g0, input logic g1,
                               input logic v0, input logic v1, input logic bwe,
                               input logic [31:0] baddr, input logic [31:0] bdin,
                               input logic [31:0] rd0, input logic [31:0] rd1);
        vec_t v;
        v.r0 = r0; v.a0 = a0; v.r1 = r1; v.a1 = a1; v.d1 = d1; v.w1 = w1;
        v.dout = dout; v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.bwe = bwe;
        v.baddr = baddr; v.bdin = bdin; v.rd0 = rd0; v.rd1 = rd1;
        return v;
    endfunction

    function automatic logic [132:0] outs0();
        return {if0.m0_gnt, if0.m1_gnt, if0.m0_rvalid, if0.m1_rvalid, if0.bus_we,
                if0.bus_addr, if0.bus_datain, if0.m0_rdata, if0.m1_rdata};
    endfunction

    function automatic logic [132:0] outs1();
        return {if1.m0_gnt, if1.m1_gnt, if1.m0_rvalid, if1.m1_rvalid, if1.bus_we,
                if1.bus_addr, if1.bus_datain, if1.m0_rdata, if1.m1_rdata};
    endfunction

    task automatic check(input string name, input logic [132:0] act,
                         input logic [132:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        if0.m0_req = 0; if0.m0_addr = 0; if0.m0_wdata = 0; if0.m0_we = 0; if0.m0_lock = 0;
        if0.m1_req = 0; if0.m1_addr = 0; if0.m1_wdata = 0; if0.m1_we = 0; if0.m1_lock = 0;
        if0.bus_dataout = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        if0.m0_req = v.r0; if0.m0_addr = v.a0; if0.m0_wdata = 0; if0.m0_we = 0; if0.m0_lock = 0;
        if0.m1_req = v.r1; if0.m1_addr = v.a1; if0.m1_wdata = v.d1; if0.m1_we = v.w1;
        if0.m1_lock = 0;
        if0.bus_dataout = v.dout;
    endtask

    // m1 takes the lock first, m0 then waits; counts m1 grants until m0 wins
    task automatic run_lock(input bit early_rel, output int cnt, output bit seen);
        cnt  = 0;
        seen = 0;
        if0.m1_req = 1; if0.m1_lock = 1; if0.m1_addr = 32'h400; if0.m1_we = 0;
        if0.m0_addr = 32'h300; if0.m0_we = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (if0.m1_gnt) begin
                cnt++;
                if (early_rel) if0.m1_lock = 0;
            end
            if (i == 0) if0.m0_req = 1;
            if (if0.m0_gnt) begin
                seen = 1;
                break;
            end
        end
        if0.m0_req = 0; if0.m1_req = 0; if0.m1_lock = 0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single read, single write, then continuous round-robin contention
        tbl[0]  = V(1, 32'hF2000000, 0, 0, 0, 0, 0,            0,0,0,0,0, 0, 0, 0, 0);
        tbl[1]  = V(1, 32'hF2000000, 0, 0, 0, 0, 0,            1,0,0,0,0, 32'hF2000000, 0, 0, 0);
        tbl[2]  = V(0, 32'hF2000000, 0, 0, 0, 0, 32'h3FF,      0,0,0,0,0, 32'hF2000000, 0, 0, 0);
        tbl[3]  = V(0, 32'hF2000000, 0, 0, 0, 0, 0,            0,0,1,0,0, 32'hF2000000, 0, 32'h3FF, 0);
        tbl[4]  = V(0, 32'hF2000000, 0, 0, 0, 0, 0,            0,0,0,0,0, 32'hF2000000, 0, 32'h3FF, 0);
        tbl[5]  = V(0, 32'hF2000000, 1, 32'hF0000000, 32'hABCDEF, 1, 0,
                    0,0,0,0,0, 32'hF2000000, 0, 32'h3FF, 0);
        tbl[6]  = V(0, 32'hF2000000, 1, 32'hF0000000, 32'hABCDEF, 1, 0,
                    0,1,0,0,1, 32'hF0000000, 32'hABCDEF, 32'h3FF, 0);
        tbl[7]  = V(0, 32'hF2000000, 0, 32'hF0000000, 32'hABCDEF, 1, 32'hDEADBEEF,
                    0,0,0,0,0, 32'hF0000000, 32'hABCDEF, 32'h3FF, 0);
        tbl[8]  = V(0, 32'hF2000000, 0, 32'hF0000000, 32'hABCDEF, 1, 0,
                    0,0,0,1,0, 32'hF0000000, 32'hABCDEF, 32'h3FF, 0);
        tbl[9]  = V(1, 32'h100, 1, 32'h200, 32'h5555, 0, 0, 0,0,0,0,0, 32'hF0000000, 32'hABCDEF, 32'h3FF, 0);
        tbl[10] = V(1, 32'h100, 1, 32'h200, 32'h5555, 0, 0, 1,0,0,0,0, 32'h100, 0, 32'h3FF, 0);
        tbl[11] = V(1, 32'h100, 1, 32'h200, 32'h5555, 0, 32'h11, 0,0,0,0,0, 32'h100, 0, 32'h3FF, 0);
        tbl[12] = V(1, 32'h100, 1, 32'h200, 32'h5555, 0, 0, 0,0,1,0,0, 32'h100, 0, 32'h11, 0);
        tbl[13] = V(1, 32'h100, 1, 32'h200, 32'h5555, 0, 0, 0,1,0,0,0, 32'h200, 32'h5555, 32'h11, 0);
        tbl[14] = V(1, 32'h100, 1, 32'h200, 32'h5555, 0, 32'h22, 0,0,0,0,0, 32'h200, 32'h5555, 32'h11, 0);
        tbl[15] = V(1, 32'h100, 1, 32'h200, 32'h5555, 0, 0, 0,0,0,1,0, 32'h200, 32'h5555, 32'h11, 32'h22);
        tbl[16] = V(1, 32'h100, 1, 32'h200, 32'h5555, 0, 0, 1,0,0,0,0, 32'h100, 0, 32'h11, 32'h22);
        tbl[17] = V(0, 32'h100, 1, 32'h200, 32'h5555, 0, 32'h33, 0,0,0,0,0, 32'h100, 0, 32'h11, 32'h22);
        tbl[18] = V(0, 32'h100, 1, 32'h200, 32'h5555, 0, 0, 0,0,1,0,0, 32'h100, 0, 32'h33, 32'h22);
        tbl[19] = V(0, 32'h100, 1, 32'h200, 32'h5555, 0, 0, 0,1,0,0,0, 32'h200, 32'h5555, 32'h33, 32'h22);
        tbl[20] = V(0, 32'h100, 0, 32'h200, 32'h5555, 0, 32'h44, 0,0,0,0,0, 32'h200, 32'h5555, 32'h33, 32'h22);
        tbl[21] = V(0, 32'h100, 0, 32'h200, 32'h5555, 0, 0, 0,0,0,1,0, 32'h200, 32'h5555, 32'h33, 32'h44);

        do_reset();
        check("reset_state", outs0(), 133'd0);

        for (int i = 0; i < 22; i++) begin
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), outs0(),
                  {tbl[i].g0, tbl[i].g1, tbl[i].v0, tbl[i].v1, tbl[i].bwe,
                   tbl[i].baddr, tbl[i].bdin, tbl[i].rd0, tbl[i].rd1});
            drive(tbl[i]);
        end

        // Lock held by m1 for 1 + LOCK_MAX grants, then broken for m0
        run_lock(1'b0, m1_cnt, m0_seen);
        check("lock_m1_grants", 133'(m1_cnt), 133'd5);
        check("lock_m0_served", 133'(m0_seen), 133'd1);

        // Lock dropped by m1 on its second transaction releases at once
        run_lock(1'b1, m1_cnt, m0_seen);
        check("unlock_m1_grants", 133'(m1_cnt), 133'd2);
        check("unlock_m0_served", 133'(m0_seen), 133'd1);

        // Continuous contention from reset on both arbitration modes
        do_reset();
        check("reset_state_fp", outs1(), 133'd0);
        if0.m0_req = 1; if0.m0_addr = 32'h10;
        if0.m1_req = 1; if0.m1_addr = 32'h20;
        if0.bus_dataout = 32'hF00D;
        n0 = 0; n1 = 0; p0 = 4'd0; p1 = 4'd0; last_c = 0; gap_ok = 1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (if0.m0_gnt || if0.m1_gnt) begin
                p0 = {p0[2:0], if0.m1_gnt};
                if (n0 == 0 && i != 0) gap_ok = 0;
                if (n0 > 0 && (i - last_c) != 3) gap_ok = 0;
                last_c = i;
                n0++;
            end
            if (if1.m0_gnt || if1.m1_gnt) begin
                p1 = {p1[2:0], if1.m1_gnt};
                n1++;
            end
        end
        if0.m0_req = 0; if0.m1_req = 0;
        check("rr_grant_order", 133'({n0[3:0], p0}), 133'({4'd4, 4'b0101}));
        check("rr_grant_spacing", 133'(gap_ok), 133'd1);
        check("fp_grant_order", 133'({n1[3:0], p1}), 133'({4'd4, 4'b0000}));
        repeat (6) @(posedge clk);
        #1;

        // Reset in the RESP cycle abandons the read
        if0.m0_req = 1; if0.m0_addr = 32'h500; if0.bus_dataout = 32'hCAFE;
        @(posedge clk); #1;
        check("rst_resp_gnt", 133'({if0.m0_gnt, if0.m1_gnt}), 133'(2'b10));
        if0.m0_req = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_resp_clear", outs0(), 133'd0);
        rst = 1'b0;
        if0.m1_req = 1; if0.m1_addr = 32'h600; if0.bus_dataout = 32'hBEEF;
        @(posedge clk); #1;
        check("rst_resp_m1_first",
              133'({if0.m0_rvalid, if0.m1_rvalid, if0.m0_gnt, if0.m1_gnt}), 133'(4'b0001));
        if0.m0_req = 1; if0.m0_addr = 32'h700;
        @(posedge clk); #1;
        if0.m1_req = 0;
        @(posedge clk); #1;
        check("rst_resp_m1_done", 133'({if0.m0_rvalid, if0.m1_rvalid, if0.m1_rdata}),
              133'({1'b0, 1'b1, 32'hBEEF}));
        @(posedge clk); #1;
        check("rst_resp_m0_next", 133'({if0.m0_gnt, if0.m1_gnt, if0.bus_addr}),
              133'({1'b1, 1'b0, 32'h700}));
        if0.m0_req = 0;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
